// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and sizing helpers for the async_fifo write-side arbiter.
package fifo_arb_pkg;

   typedef enum logic {IDLE, BUSY} arb_state_t;

   localparam int N_REQ_MIN     = 2;
   localparam int N_REQ_MAX     = 8;
   localparam int MAX_BURST_MIN = 1;
   localparam int MAX_BURST_MAX = 16;

   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin search for the first set request after last_i.
module rr_priority_pick
   import fifo_arb_pkg::*;
#(
   parameter int  N_REQ = 4,
   localparam int IW    = id_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IW-1:0]    last_i,
   output logic             found_o,
   output logic [IW-1:0]    idx_o
);

   // Walk from the farthest offset down so the nearest set bit after last_i wins; offset N_REQ is last_i itself.
   always_comb begin
      found_o = |req_i;
      idx_o   = last_i;
      for (int j = N_REQ; j >= 1; j--) begin
         if (req_i[(int'(last_i) + j) % N_REQ]) idx_o = IW'((int'(last_i) + j) % N_REQ);
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the async_fifo write port among N_REQ valid/ready requesters.
// Define FIFO_WR_ARB_BURST_LOCK_EN to let an owner keep the grant for up to MAX_BURST consecutive beats.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int  N_REQ      = 4,
   parameter int  DATA_WIDTH = 8,
   parameter int  MAX_BURST  = 4,
   localparam int IW         = id_w(N_REQ)
) (
   input  logic                        wr_clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            req_ready,
   input  logic                        full,
   output logic                        wr_en,
   output logic [DATA_WIDTH-1:0]       write_data,
   output logic                        grant_valid,
   output logic [IW-1:0]               grant_id
);

   logic [N_REQ-1:0] vld;
   logic [IW-1:0]    rr_last_q, rr_last_d, cand, owner;
   logic             found, locked;

   // Masking requests during reset makes every output fall to its reset value without waiting for a clock.
   assign vld = rst_n ? req_valid : '0;

   rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
      .req_i   (vld),
      .last_i  (rr_last_q),
      .found_o (found),
      .idx_o   (cand)
   );

`ifdef FIFO_WR_ARB_BURST_LOCK_EN
   localparam int CW = $clog2(MAX_BURST + 1);

   arb_state_t    state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // A locked owner that drops valid hands over in the same cycle, so release costs no bubble.
   assign locked = (state_q == BUSY) & vld[owner_q];
   assign owner  = locked ? owner_q : cand;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      if (!full) begin
         if (wr_en && locked) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(MAX_BURST)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end else if (wr_en && MAX_BURST > 1) begin
            state_d = BUSY;
            owner_d = cand;
            cnt_d   = CW'(1);
         end else if (!locked) begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   assign locked = 1'b0;
   assign owner  = cand;
`endif

   assign grant_valid = locked | found;
   assign grant_id    = owner;
   assign wr_en       = grant_valid & vld[owner] & ~full;
   assign write_data  = req_data[owner*DATA_WIDTH +: DATA_WIDTH];
   assign req_ready   = (grant_valid & ~full) ? (N_REQ'(1) << owner) : '0;
   assign rr_last_d   = wr_en ? owner : rr_last_q;

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) rr_last_q <= IW'(N_REQ - 1);
      else        rr_last_q <= rr_last_d;
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized self-checking bench with a behavioural round-robin model.
// Honours FIFO_WR_ARB_BURST_LOCK_EN so the same bench covers both builds.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;
`ifdef FIFO_WR_ARB_BURST_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          full  = 1'b0;
   logic [N-1:0]  vld   = '0;
   logic [N*DW-1:0] dat = '0;
   logic [N-1:0]  rdy;
   logic          wr_en, gv;
   logic [DW-1:0] wd;
   logic [1:0]    gid;

   int n_chk = 0, n_fail = 0;
   int rr, own, cnt;
   bit busy;
   bit e_gv, e_wr;
   int e_gid;
   logic [N-1:0] e_rdy;
   int last_gid;
   bit last_wr, last_gv;
   logic [DW-1:0] last_wd;
   logic [N-1:0]  last_rdy;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .wr_clk      (clk),
      .rst_n       (rst_n),
      .req_valid   (vld),
      .req_data    (dat),
      .req_ready   (rdy),
      .full        (full),
      .wr_en       (wr_en),
      .write_data  (wd),
      .grant_valid (gv),
      .grant_id    (gid)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      rr   = N - 1;
      own  = 0;
      cnt  = 0;
      busy = 1'b0;
   endtask

   // Owner: the locked requester if it still has a beat, else the first valid one after the last served.
   task automatic model_eval();
      logic [N-1:0] v;
      v     = rst_n ? vld : '0;
      e_gv  = 1'b0;
      e_gid = rr;
      if (LOCK && busy && v[own]) begin
         e_gv  = 1'b1;
         e_gid = own;
      end else begin
         for (int k = 1; k <= N; k++) begin
            if (!e_gv && v[(rr + k) % N]) begin
               e_gv  = 1'b1;
               e_gid = (rr + k) % N;
            end
         end
      end
      e_wr  = e_gv && v[e_gid] && !full;
      e_rdy = (e_gv && !full) ? (N'(1) << e_gid) : '0;
   endtask

   task automatic model_update(output logic [N-1:0] acc);
      bit held;
      model_eval();
      acc = e_rdy & vld;
      if (!rst_n) begin
         model_reset();
         acc = '0;
      end else if (e_wr) begin
         held = LOCK && busy && vld[own];
         rr   = e_gid;
         if (LOCK) begin
            if (held) begin
               cnt++;
               if (cnt == MB) begin
                  busy = 1'b0;
                  cnt  = 0;
               end
            end else if (MB > 1) begin
               busy = 1'b1;
               own  = e_gid;
               cnt  = 1;
            end
         end
      end else if (LOCK && busy && !full && !vld[own]) begin
         busy = 1'b0;
         cnt  = 0;
      end
   endtask

   task automatic check();
      model_eval();
      chk("grant_valid", int'(gv), int'(e_gv));
      chk("grant_id", int'(gid), e_gid);
      chk("wr_en", int'(wr_en), int'(e_wr));
      chk("req_ready", int'(rdy), int'(e_rdy));
      if (e_gv) chk("write_data", int'(wd), int'(dat[e_gid*DW +: DW]));
      last_gid = gid;
      last_wr  = wr_en;
      last_gv  = gv;
      last_wd  = wd;
      last_rdy = rdy;
   endtask

   // Compare at the falling edge, advance the model at the rising edge, return 1 time unit after it.
   task automatic step(output logic [N-1:0] acc);
      @(negedge clk);
      check();
      @(posedge clk);
      model_update(acc);
      #1;
   endtask

   task automatic drive_random(input logic [N-1:0] acc);
      for (int i = 0; i < N; i++) begin
         if (!(vld[i] && !acc[i])) begin
            vld[i]            = ($urandom_range(0, 99) < 60);
            dat[i*DW +: DW]   = DW'($urandom);
         end
      end
      full = ($urandom_range(0, 3) == 0);
   endtask

   initial begin
      logic [N-1:0] acc;
      model_reset();
      vld = '1;
      dat = {8'h13, 8'h12, 8'h11, 8'h10};
      repeat (2) step(acc);
      chk("reset_wr_en", int'(wr_en), 0);
      chk("reset_ready", int'(rdy), 0);
      chk("reset_grant_valid", int'(gv), 0);
      chk("reset_grant_id", int'(gid), N - 1);

      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(acc);
         chk("rr_grant_seq", last_gid, LOCK ? (i < 4 ? 0 : 1) : i % 4);
         chk("rr_write", int'(last_wr), 1);
      end

      vld = 4'b1010;
      dat = {8'hA3, 8'h00, 8'hA1, 8'h00};
      for (int i = 0; i < 4; i++) begin
         step(acc);
         chk("sparse_data", int'(last_wd),
             LOCK ? (i < 3 ? 'hA1 : 'hA3) : (i % 2 == 1 ? 'hA3 : 'hA1));
      end

      vld  = 4'b0100;
      dat  = {8'h00, 8'h5C, 8'h00, 8'h00};
      full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(acc);
         chk("bp_wr_en", int'(last_wr), 0);
         chk("bp_ready", int'(last_rdy), 0);
      end
      full = 1'b0;
      step(acc);
      chk("bp_release_wr", int'(last_wr), 1);
      chk("bp_release_data", int'(last_wd), 'h5C);
      vld = '0;
      step(acc);
      chk("idle_wr_en", int'(last_wr), 0);
      chk("idle_grant_valid", int'(last_gv), 0);
      chk("idle_grant_id", last_gid, 2);

      acc = '0;
      for (int c = 0; c < 3000; c++) begin
         drive_random(acc);
         step(acc);
      end

      vld  = '1;
      full = 1'b0;
      repeat (2) step(acc);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_wr_en", int'(wr_en), 0);
      chk("async_rst_ready", int'(rdy), 0);
      chk("async_rst_grant_valid", int'(gv), 0);
      chk("async_rst_grant_id", int'(gid), N - 1);
      model_reset();
      repeat (2) step(acc);
      rst_n = 1'b1;
      step(acc);
      chk("post_rst_first_grant", last_gid, 0);
      chk("post_rst_write", int'(last_wr), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
